// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and types for the framebuffer access scheduler.
//   FRAME_COLS / FRAME_ROWS : visible frame geometry
//   FB_ADDR_W               : framebuffer cell address width
//   cell_t                  : cell contents stored in the framebuffer
//   sched_state_t           : simulation sequencing state
//   requester_t             : framebuffer requesters (used for the round-robin pointer)
package fb_pkg;

  localparam int FRAME_COLS = 640;
  localparam int FRAME_ROWS = 400;
  localparam int FB_ADDR_W  = $clog2(FRAME_COLS * FRAME_ROWS);
  localparam int CELL_W     = 2;

  typedef enum logic [CELL_W-1:0] {
    EMPTY = 2'd0,
    SAND  = 2'd1,
    WALL  = 2'd2,
    WATER = 2'd3
  } cell_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  typedef enum logic [1:0] {
    DISP = 2'd0,
    DRAW = 2'd1,
    SIM  = 2'd2
  } requester_t;

endpackage

// File: rtl/frame_sequencer.sv
// frame_sequencer: detects the vsync rising edge (frame tick) and launches one
// simulation pass per frame, flagging frames whose tick arrives while the
// previous pass is still running.
//   clk_i, reset_i     : clock, asynchronous active-high reset
//   sim_enable_i       : allow new passes (low = paused)
//   vsync_i            : vertical sync
//   sim_done_i         : pass-complete pulse from the engine
//   running_o          : a pass is in progress (gates engine grants)
//   sim_start_o        : one-cycle start pulse, high on the first RUN cycle
//   overrun_o          : sticky overrun flag
//   overrun_count_o    : saturating overrun count when FB_ARB_OVERRUN_COUNT_EN
//                        is defined, otherwise constant 0
module frame_sequencer
  import fb_pkg::*;
#(
  parameter int OVR_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sim_enable_i,
  input  logic             vsync_i,
  input  logic             sim_done_i,
  output logic             running_o,
  output logic             sim_start_o,
  output logic             overrun_o,
  output logic [OVR_W-1:0] overrun_count_o
);

  sched_state_t state_q, state_d;
  logic         vsync_q;
  logic         start_q, start_d;
  logic         overrun_q, overrun_d;
  logic         frame_tick;
  logic         overrun_event;

  always_comb begin
    frame_tick    = vsync_i & ~vsync_q;
    state_d       = state_q;
    start_d       = 1'b0;
    overrun_d     = overrun_q;
    overrun_event = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick && sim_enable_i) begin
          state_d = RUN;
          start_d = 1'b1;
        end
      end
      RUN: begin
        if (sim_done_i) begin
          // A tick coinciding with completion chains straight into the next pass.
          if (frame_tick && sim_enable_i) begin
            start_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (frame_tick) begin
          overrun_d     = 1'b1;
          overrun_event = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      vsync_q   <= 1'b0;
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= vsync_i;
      start_q   <= start_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef FB_ARB_OVERRUN_COUNT_EN
  logic [OVR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (overrun_event && (count_q != {OVR_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign overrun_count_o = count_q;
`else
  assign overrun_count_o = '0;
`endif

  assign running_o   = (state_q == RUN);
  assign sim_start_o = start_q;
  assign overrun_o   = overrun_q;

endmodule

// File: rtl/fb_access_scheduler.sv
// fb_access_scheduler: owns the single-port cell framebuffer and shares it
// between display fetch (highest priority), the sand engine and the draw brush.
// Optional feature macro: FB_ARB_OVERRUN_COUNT_EN (saturating overrun counter).
//   clk_i, reset_i                     : clock, asynchronous active-high reset
//   sim_enable_i, vsync_i              : frame sequencing inputs
//   video_en_i, pixel_i                : display read request / address
//   disp_data_o, disp_valid_o          : display data, 2 cycles after request
//   sim_start_o, sim_done_i            : engine pass handshake
//   sim_req/we/addr/wdata_i, sim_gnt_o : engine access port (granted only in RUN)
//   sim_rvalid_o, sim_rdata_o          : engine read data, 2 cycles after grant
//   draw_req/addr/wdata_i, draw_gnt_o  : brush write port
//   mem_en/we/addr/wdata_o, mem_rdata_i: RAM port (registered command, 1-cycle read)
//   overrun_o, overrun_count_o         : frame overrun status
module fb_access_scheduler
  import fb_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = FRAME_COLS,
  parameter int ACTIVE_ROWS    = FRAME_ROWS,
  parameter int ADDR_W         = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_W         = 2,
  parameter int OVR_W          = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sim_enable_i,
  input  logic              vsync_i,
  input  logic              video_en_i,
  input  logic [ADDR_W-1:0] pixel_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  output logic              sim_start_o,
  input  logic              sim_done_i,
  input  logic              sim_req_i,
  input  logic              sim_we_i,
  input  logic [ADDR_W-1:0] sim_addr_i,
  input  logic [DATA_W-1:0] sim_wdata_i,
  output logic              sim_gnt_o,
  output logic              sim_rvalid_o,
  output logic [DATA_W-1:0] sim_rdata_o,
  input  logic              draw_req_i,
  input  logic [ADDR_W-1:0] draw_addr_i,
  input  logic [DATA_W-1:0] draw_wdata_i,
  output logic              draw_gnt_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              overrun_o,
  output logic [OVR_W-1:0]  overrun_count_o
);

  logic running;

  frame_sequencer #(
    .OVR_W(OVR_W)
  ) u_frame_sequencer (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .sim_enable_i   (sim_enable_i),
    .vsync_i        (vsync_i),
    .sim_done_i     (sim_done_i),
    .running_o      (running),
    .sim_start_o    (sim_start_o),
    .overrun_o      (overrun_o),
    .overrun_count_o(overrun_count_o)
  );

  // Round-robin pointer names the requester favoured on the next contested cycle.
  requester_t        rr_q, rr_d;
  logic              sim_gnt, draw_gnt;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  // Read tags: stage 1 travels with the RAM command, stage 2 marks RAM data.
  logic              disp_rd_q, disp_rd_d;
  logic              sim_rd_q, sim_rd_d;
  logic              disp_vld_q, disp_vld_d;
  logic              sim_vld_q, sim_vld_d;

  always_comb begin
    sim_gnt  = 1'b0;
    draw_gnt = 1'b0;
    rr_d     = rr_q;
    // Grants are held low during reset so every output reads 0 immediately.
    if (!reset_i && !video_en_i) begin
      if (sim_req_i && running && (!draw_req_i || rr_q == SIM)) begin
        sim_gnt = 1'b1;
        rr_d    = DRAW;
      end else if (draw_req_i) begin
        draw_gnt = 1'b1;
        rr_d     = SIM;
      end
    end
  end

  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    disp_rd_d   = 1'b0;
    sim_rd_d    = 1'b0;
    if (video_en_i) begin
      mem_en_d   = 1'b1;
      mem_addr_d = pixel_i;
      disp_rd_d  = 1'b1;
    end else if (sim_gnt) begin
      mem_en_d   = 1'b1;
      mem_we_d   = sim_we_i;
      mem_addr_d = sim_addr_i;
      if (sim_we_i) begin
        mem_wdata_d = sim_wdata_i;
      end else begin
        sim_rd_d = 1'b1;
      end
    end else if (draw_gnt) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = draw_addr_i;
      mem_wdata_d = draw_wdata_i;
    end
    disp_vld_d = disp_rd_q;
    sim_vld_d  = sim_rd_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_q        <= SIM;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      disp_rd_q   <= 1'b0;
      sim_rd_q    <= 1'b0;
      disp_vld_q  <= 1'b0;
      sim_vld_q   <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      disp_rd_q   <= disp_rd_d;
      sim_rd_q    <= sim_rd_d;
      disp_vld_q  <= disp_vld_d;
      sim_vld_q   <= sim_vld_d;
    end
  end

  assign sim_gnt_o    = sim_gnt;
  assign draw_gnt_o   = draw_gnt;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  // RAM data is forwarded only when tagged, so idle outputs stay at 0.
  assign disp_valid_o = disp_vld_q;
  assign disp_data_o  = disp_vld_q ? mem_rdata_i : '0;
  assign sim_rvalid_o = sim_vld_q;
  assign sim_rdata_o  = sim_vld_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_fb_access_scheduler.sv
// Testbench for fb_access_scheduler: randomized and directed stimulus checked
// against a behavioural model; read responses go through a scoreboard queue.
module tb_fb_access_scheduler;

  localparam int AW = 18;
  localparam int DW = 2;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          sim_enable_i, vsync_i, video_en_i;
  logic [AW-1:0] pixel_i;
  logic [DW-1:0] disp_data_o;
  logic          disp_valid_o, sim_start_o, sim_done_i;
  logic          sim_req_i, sim_we_i;
  logic [AW-1:0] sim_addr_i;
  logic [DW-1:0] sim_wdata_i;
  logic          sim_gnt_o, sim_rvalid_o;
  logic [DW-1:0] sim_rdata_o;
  logic          draw_req_i;
  logic [AW-1:0] draw_addr_i;
  logic [DW-1:0] draw_wdata_i;
  logic          draw_gnt_o, mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          overrun_o;
  logic [OW-1:0] overrun_count_o;

  always #5 clk = ~clk;

  fb_access_scheduler dut (
    .clk_i(clk), .reset_i(reset_i), .sim_enable_i(sim_enable_i), .vsync_i(vsync_i),
    .video_en_i(video_en_i), .pixel_i(pixel_i), .disp_data_o(disp_data_o),
    .disp_valid_o(disp_valid_o), .sim_start_o(sim_start_o), .sim_done_i(sim_done_i),
    .sim_req_i(sim_req_i), .sim_we_i(sim_we_i), .sim_addr_i(sim_addr_i),
    .sim_wdata_i(sim_wdata_i), .sim_gnt_o(sim_gnt_o), .sim_rvalid_o(sim_rvalid_o),
    .sim_rdata_o(sim_rdata_o), .draw_req_i(draw_req_i), .draw_addr_i(draw_addr_i),
    .draw_wdata_i(draw_wdata_i), .draw_gnt_o(draw_gnt_o), .mem_en_o(mem_en_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .overrun_o(overrun_o), .overrun_count_o(overrun_count_o)
  );

  // Framebuffer RAM with one-cycle synchronous read.
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= ram[mem_addr_o];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    bit            is_sim;
    logic [DW-1:0] data;
    int            due;
  } item_t;
  item_t sb[$];

  // Reference model state.
  bit            m_run, m_start, m_ovr, m_prev_vs, m_favor_sim;
  logic [OW-1:0] m_cnt;
  bit            e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  bit            g_sim, g_draw;

  task automatic model_reset();
    m_run = 0; m_start = 0; m_ovr = 0; m_prev_vs = 0; m_favor_sim = 1; m_cnt = '0;
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; g_sim = 0; g_draw = 0;
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {disp_valid_o, sim_start_o, sim_gnt_o, sim_rvalid_o,
                         draw_gnt_o, mem_en_o, mem_we_o, overrun_o}, 0);
    chk({tag, "_data"}, {disp_data_o, sim_rdata_o, mem_wdata_o}, 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_count"}, overrun_count_o, 0);
  endtask

  // One clock cycle: compare this cycle's outputs with the model, then advance it.
  task automatic step();
    bit    tick, es, ed, sim_ok;
    item_t it;
    @(negedge clk);
    chk("sim_start", sim_start_o, m_start);
    chk("overrun", overrun_o, m_ovr);
`ifdef FB_ARB_OVERRUN_COUNT_EN
    chk("overrun_count", overrun_count_o, m_cnt);
`else
    chk("overrun_count", overrun_count_o, 0);
`endif
    chk("mem_en", mem_en_o, e_en);
    chk("mem_we", mem_we_o, e_we);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_wdata", mem_wdata_o, e_wd);

    sim_ok = sim_req_i && m_run;
    es = 0; ed = 0;
    if (!video_en_i) begin
      if (sim_ok && draw_req_i) begin
        es = m_favor_sim; ed = !m_favor_sim;
      end else begin
        es = sim_ok; ed = draw_req_i;
      end
    end
    chk("sim_gnt", sim_gnt_o, es);
    chk("draw_gnt", draw_gnt_o, ed);
    g_sim = es; g_draw = ed;
    if (es) m_favor_sim = 0;
    if (ed) m_favor_sim = 1;

    e_en = 0; e_we = 0;
    if (video_en_i) begin
      e_en = 1; e_addr = pixel_i;
      it.is_sim = 0; it.data = ref_mem[pixel_i]; it.due = cyc + 2; sb.push_back(it);
    end else if (es) begin
      e_en = 1; e_we = sim_we_i; e_addr = sim_addr_i;
      if (sim_we_i) begin
        e_wd = sim_wdata_i; ref_mem[sim_addr_i] = sim_wdata_i;
      end else begin
        it.is_sim = 1; it.data = ref_mem[sim_addr_i]; it.due = cyc + 2; sb.push_back(it);
      end
    end else if (ed) begin
      e_en = 1; e_we = 1; e_addr = draw_addr_i; e_wd = draw_wdata_i;
      ref_mem[draw_addr_i] = draw_wdata_i;
    end

    tick = vsync_i && !m_prev_vs;
    m_prev_vs = vsync_i;
    m_start = 0;
    if (!m_run) begin
      if (tick && sim_enable_i) begin m_run = 1; m_start = 1; end
    end else if (sim_done_i) begin
      if (tick && sim_enable_i) m_start = 1;
      else m_run = 0;
    end else if (tick) begin
      m_ovr = 1;
      if (m_cnt != {OW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    @(posedge clk); #1;
  endtask

  // Reset asserted mid-cycle; outputs must drop at once and no read may complete afterwards.
  task automatic do_reset();
    #2 reset_i = 1;
    #1 check_zero("mid_reset");
    @(posedge clk); #1;
    model_reset();
    reset_i = 0;
  endtask

  // Monitor: every read response the DUT presents must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset_i && (disp_valid_o || sim_rvalid_o)) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_read: disp_valid=%0b sim_rvalid=%0b with no read pending (cycle %0d)",
                 disp_valid_o, sim_rvalid_o, cyc);
      end else begin
        item_t it;
        it = sb.pop_front();
        chk("rd_source", {disp_valid_o, sim_rvalid_o}, it.is_sim ? 2'b01 : 2'b10);
        chk("rd_latency", cyc, it.due);
        chk("rd_data", it.is_sim ? sim_rdata_o : disp_data_o, it.data);
      end
    end
  end

  initial begin
    logic [DW-1:0] v;
    reset_i = 1; sim_enable_i = 0; vsync_i = 0; video_en_i = 0; pixel_i = '0;
    sim_done_i = 0; sim_req_i = 0; sim_we_i = 0; sim_addr_i = '0; sim_wdata_i = '0;
    draw_req_i = 0; draw_addr_i = '0; draw_wdata_i = '0;
    for (int i = 0; i < 64; i++) begin
      v = DW'($urandom); ram[i] = v; ref_mem[i] = v;
    end
    ram[5] = 2'b01;    ref_mem[5] = 2'b01;
    ram[1234] = 2'b11; ref_mem[1234] = 2'b11;
    @(posedge clk); #1;
    check_zero("reset");
    @(posedge clk); #1;
    model_reset();
    reset_i = 0;

    // Frame start: start pulse one cycle after the vsync edge.
    step();
    sim_enable_i = 1; vsync_i = 1;
    step(); step(); step();

    // Display has priority over both other requesters.
    video_en_i = 1; pixel_i = 1234;
    sim_req_i = 1; sim_we_i = 1; sim_addr_i = 10; sim_wdata_i = 2'd3;
    draw_req_i = 1; draw_addr_i = 11; draw_wdata_i = 2'd2;
    step();
    video_en_i = 0;

    // Blanking with both held: grants alternate sim, draw, sim, draw.
    for (int i = 0; i < 4; i++) begin
      step();
      if (g_sim)  begin sim_addr_i = 12; sim_wdata_i = 2'd1; end
      if (g_draw) begin draw_addr_i = 13; draw_wdata_i = 2'd0; end
    end
    sim_req_i = 0; draw_req_i = 0;
    for (int a = 10; a < 14; a++) begin
      video_en_i = 1; pixel_i = AW'(a); step();
    end
    video_en_i = 0;

    // Engine read of a preloaded cell.
    sim_req_i = 1; sim_we_i = 0; sim_addr_i = 5;
    step();
    sim_req_i = 0;
    step(); step(); step();

    // Overrun, then done and edge together.
    vsync_i = 0; step();
    vsync_i = 1; step(); step();
    vsync_i = 0; step();
    vsync_i = 1; sim_done_i = 1; step();
    sim_done_i = 0; step(); step();

    // Reset while an engine read is in flight.
    sim_req_i = 1; sim_we_i = 0; sim_addr_i = 7;
    step();
    sim_req_i = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      video_en_i = ($urandom % 4 == 0);
      pixel_i    = AW'($urandom % 64);
      if (!sim_req_i || g_sim) begin
        sim_req_i = $urandom % 2; sim_we_i = $urandom % 2;
        sim_addr_i = AW'($urandom % 64); sim_wdata_i = DW'($urandom);
      end
      if (!draw_req_i || g_draw) begin
        draw_req_i = $urandom % 2;
        draw_addr_i = AW'($urandom % 64); draw_wdata_i = DW'($urandom);
      end
      sim_done_i = m_run && ($urandom % 10 == 0);
      if ($urandom % 12 == 0) vsync_i = ~vsync_i;
      sim_enable_i = ($urandom % 8 != 0);
      if ($urandom % 700 == 0) do_reset();
      step();
    end

    video_en_i = 0; sim_req_i = 0; draw_req_i = 0; sim_done_i = 0;
    for (int i = 0; i < 5; i++) step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
